// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/valid instruction
// memory handshake and produces the IF/ID register for decode. Handles stall,
// decode-resolved redirects (no delay slot) and discard of stale responses.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [1:0]  Jump,
  input  logic        Branch,
  input  logic        BranchCond,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        InstValid,
  output logic        FetchBusy
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic            valid_q, valid_d;

  logic            jump_taken;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            load_word;
  logic [XLEN-1:0] load_data;

  // Redirect decode: Jump outranks Branch, 2'b11 behaves as sequential.
  always_comb begin
    jump_taken = (Jump == 2'b01) || (Jump == 2'b10);
    redirect   = ~Stall & valid_q & (jump_taken | (Branch & BranchCond));
    target     = ((Jump == 2'b10) ? JrTarget : JumpTarget) & ALIGN_MASK;
  end

  // Next-state: fetch sequencing, PC update and IF/ID load/squash.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    buf_d     = buf_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    load_word = 1'b0;
    load_data = BUBBLE;

    unique case (state_q)
      ST_REQ: begin
        // Request goes out this cycle; a redirect now makes its answer stale.
        state_d = ST_WAIT;
        if (redirect) begin
          pc_d      = target;
          discard_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (!imem_valid) begin
          if (redirect) begin
            pc_d      = target;
            discard_d = 1'b1;
          end
        end else if (discard_q || redirect) begin
          // Wrong-path word: drop it and refetch from the current PC.
          discard_d = 1'b0;
          state_d   = ST_REQ;
          if (redirect) begin
            pc_d = target;
          end
        end else if (!Stall) begin
          load_word = 1'b1;
          load_data = imem_rdata;
          pc_d      = pc_q + PC_STEP;
          state_d   = ST_REQ;
        end else begin
          // Decode is stalled: park the word until IF/ID can take it.
          buf_d   = imem_rdata;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!Stall) begin
          state_d = ST_REQ;
          if (redirect) begin
            pc_d = target;
          end else begin
            load_word = 1'b1;
            load_data = buf_q;
            pc_d      = pc_q + PC_STEP;
          end
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase

    // IF/ID holds under stall; otherwise it takes the word or a bubble.
    if (!Stall) begin
      instr_d   = load_word ? load_data : BUBBLE;
      ifid_pc_d = pc_q;
      valid_d   = load_word;
    end
  end

  // State, PC and IF/ID registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC & ALIGN_MASK;
      discard_q <= 1'b0;
      buf_q     <= BUBBLE;
      instr_q   <= BUBBLE;
      ifid_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      buf_q     <= buf_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
    end
  end

  // Request is held low while reset is asserted, so it starts right after release.
  assign imem_req    = (state_q == ST_REQ) & reset;
  assign imem_addr   = pc_q & ALIGN_MASK;
  assign FetchBusy   = (state_q == ST_WAIT);
  assign Instruction = instr_q;
  assign PC          = ifid_pc_q;
  assign InstValid   = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: random stall/redirect traffic and a latency-varying
// memory, checked every cycle against a transaction-level fetch model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic [1:0]  Jump;
  logic        Branch;
  logic        BranchCond;
  logic [31:0] JumpTarget;
  logic [31:0] JrTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        InstValid;
  logic        FetchBusy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .BUBBLE(BUBBLE)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Jump(Jump), .Branch(Branch),
    .BranchCond(BranchCond), .JumpTarget(JumpTarget), .JrTarget(JrTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .Instruction(Instruction), .PC(PC),
    .InstValid(InstValid), .FetchBusy(FetchBusy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Contents of instruction memory at any address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Reference model: what fetch is doing (issuing, awaiting, holding a word),
  // whether the awaited answer is stale, the next fetch PC and the IF/ID view.
  bit          m_issue, m_pending, m_stale, m_held;
  logic [31:0] m_pc, m_hw, m_instr, m_ifpc;
  bit          m_valid;

  task automatic model_reset();
    m_issue = 1; m_pending = 0; m_stale = 0; m_held = 0;
    m_pc = RESET_PC; m_hw = BUBBLE;
    m_instr = BUBBLE; m_ifpc = RESET_PC; m_valid = 0;
  endtask

  task automatic model_check(input bit in_reset);
    chk("imem_req",    32'(imem_req),  32'(m_issue && !in_reset));
    chk("imem_addr",   imem_addr,      m_pc);
    chk("Instruction", Instruction,    m_instr);
    chk("PC",          PC,             m_ifpc);
    chk("InstValid",   32'(InstValid), 32'(m_valid));
    chk("FetchBusy",   32'(FetchBusy), 32'(m_pending));
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit          redir, load;
    logic [31:0] tgt, pc_before, w;
    redir = !Stall && m_valid &&
            (Jump == 2'b01 || Jump == 2'b10 || (Branch && BranchCond));
    tgt = ((Jump == 2'b10) ? JrTarget : JumpTarget) & ~32'd3;
    pc_before = m_pc;
    load = 0;
    w = BUBBLE;
    if (m_issue) begin
      m_issue = 0;
      m_pending = 1;
      if (redir) begin m_pc = tgt; m_stale = 1; end
    end else if (m_pending) begin
      if (imem_valid) begin
        m_pending = 0;
        if (m_stale || redir) begin
          m_stale = 0;
          m_issue = 1;
          if (redir) m_pc = tgt;
        end else if (!Stall) begin
          load = 1;
          w = mem_word(pc_before);
          m_pc = pc_before + 32'd4;
          m_issue = 1;
        end else begin
          m_held = 1;
          m_hw = mem_word(pc_before);
        end
      end else if (redir) begin
        m_pc = tgt;
        m_stale = 1;
      end
    end else if (m_held) begin
      if (!Stall) begin
        m_held = 0;
        m_issue = 1;
        if (redir) m_pc = tgt;
        else begin
          load = 1;
          w = m_hw;
          m_pc = pc_before + 32'd4;
        end
      end
    end
    if (!Stall) begin
      m_instr = load ? w : BUBBLE;
      m_ifpc  = pc_before;
      m_valid = load;
    end
  endtask

  // Memory: one outstanding request, answered after 1..lat_max cycles.
  bit          mo;
  int          mcnt;
  logic [31:0] maddr;
  int          lat_max = 1;

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return $urandom & 32'h0000_0FFF;
  endfunction

  task automatic drive_idle();
    Stall = 0; Jump = 2'b00; Branch = 0; BranchCond = 0;
    JumpTarget = 32'h0; JrTarget = 32'h0;
    imem_valid = 0; imem_rdata = 32'h0;
  endtask

  task automatic do_cycle(input bit quiet);
    int r;
    @(negedge clk);
    if (mo) begin
      if (mcnt == 0) begin
        imem_valid = 1; imem_rdata = mem_word(maddr); mo = 0;
      end else begin
        mcnt--; imem_valid = 0; imem_rdata = $urandom;
      end
    end else begin
      imem_valid = quiet ? 1'b0 : ($urandom_range(0, 7) == 0);
      imem_rdata = $urandom;
    end
    model_check(0);
    if (imem_req) begin
      mo = 1;
      maddr = imem_addr;
      mcnt = $urandom_range(1, lat_max) - 1;
    end
    if (quiet) begin
      Stall = 0; Jump = 2'b00; Branch = 0; BranchCond = 0;
    end else begin
      Stall = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      Jump = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      Branch = ($urandom_range(0, 5) == 0);
      BranchCond = 1'($urandom_range(0, 1));
      JumpTarget = rand_target();
      JrTarget = rand_target();
    end
    model_step();
  endtask

  task automatic apply_reset_and_release();
    drive_idle();
    model_reset();
    mo = 0;
    repeat (2) begin
      @(negedge clk);
      model_check(1);
    end
    @(posedge clk);
    #1 reset = 1;
  endtask

  initial begin
    bit found;
    reset = 0;
    drive_idle();
    apply_reset_and_release();

    // Straight-line fetch, 1-cycle memory: words land on alternate cycles.
    lat_max = 1;
    repeat (20) do_cycle(1);

    // Random stall / redirect / latency traffic.
    lat_max = 3;
    repeat (1500) do_cycle(0);

    // Reset while a request is outstanding.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      do_cycle(1);
      if (mo && mcnt >= 1) found = 1;
    end
    chk("wait_for_busy", 32'(found), 32'd1);
    @(posedge clk);
    #2;
    chk("busy_before_reset", 32'(FetchBusy), 32'd1);
    reset = 0;
    #1;
    chk("rst_imem_req",    32'(imem_req),  32'd0);
    chk("rst_imem_addr",   imem_addr,      RESET_PC);
    chk("rst_Instruction", Instruction,    BUBBLE);
    chk("rst_PC",          PC,             RESET_PC);
    chk("rst_InstValid",   32'(InstValid), 32'd0);
    chk("rst_FetchBusy",   32'(FetchBusy), 32'd0);
    apply_reset_and_release();

    repeat (400) do_cycle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that produces the IF/ID pipeline register read by the decode stage: instruction word, instruction address and a valid flag.
- Consumes decode's redirect outputs: Jump, Branch, BranchCond, JumpTarget, plus a register target for jr/jalr.
- Owns the PC, fetches over a request/response instruction-memory handshake, and handles stall, redirect squash and stale-response discard.
- Branches resolve in decode with no delay slot.

Parameters:
RESET_PC  32'h0000_0000  PC loaded on reset
BUBBLE    32'h0000_0000  instruction word inserted on squash or empty slot (sll $0,$0,0)

Ports:
clk         in   1   clock, rising edge
reset       in   1   asynchronous, active-low reset
Stall       in   1   hazard unit: hold PC and IF/ID
Jump        in   2   decode: 00 sequential, 01 j/jal, 10 jr/jalr, 11 reserved (treated as 00)
Branch      in   1   decode: instruction in ID is a branch
BranchCond  in   1   decode: branch condition true
JumpTarget  in   32  decode: j/jal or branch target
JrTarget    in   32  forwarded rs value for jr/jalr
imem_req    out  1   one-cycle fetch request pulse
imem_addr   out  32  fetch address, bits [1:0] always 00
imem_rdata  in   32  fetched word
imem_valid  in   1   response strobe, at least 1 cycle after imem_req
Instruction out  32  IF/ID instruction
PC          out  32  IF/ID address of that instruction (not PC+4)
InstValid   out  1   IF/ID holds a real instruction
FetchBusy   out  1   request outstanding (state WAIT)

Behaviour:
Reset (reset=0, async):
- pc_q=RESET_PC; Instruction=BUBBLE; PC=RESET_PC; InstValid=0; imem_req=0.
- discard=0; state=REQ.
- First request issues in the first cycle after release.

Redirect:
- Condition: redirect = ~Stall & InstValid & (Jump==01 | Jump==10 | (Branch & BranchCond)).
- Target: Jump==10 selects JrTarget; otherwise JumpTarget. Bits [1:0] are cleared.
- Jump has priority over Branch.

REQ state:
- imem_req=1, imem_addr=pc_q. Next state is WAIT.
- If redirect occurs in the same cycle: pc_q<=target, discard<=1.

WAIT state:
- imem_req=0, FetchBusy=1.
- Without imem_valid: on redirect, pc_q<=target and discard<=1.
- With imem_valid and (discard | redirect): drop the word, clear discard, pc_q<=target on redirect, go REQ.
- With imem_valid, no discard, ~Stall: IF/ID<={imem_rdata, pc_q, 1}; pc_q<=pc_q+4; go REQ.
- With imem_valid, no discard, Stall: buffer the word, go HOLD.

HOLD state:
- imem_req=0.
- On ~Stall: if redirect, drop the buffer and pc_q<=target; otherwise IF/ID<=buffer and pc_q<=pc_q+4. Go REQ.

IF/ID register rules:
- Stall=1: holds all fields unchanged, including across a redirect (redirect requires ~Stall).
- Stall=0 with no word loaded this cycle, or any redirect: loads {BUBBLE, pc_q, 0}, so the wrong-path slot is squashed.

Other rules:
- imem_valid in REQ or HOLD is ignored.
- pc_q+4 wraps modulo 2^32.
- Throughput is at most one instruction per 2 cycles: REQ, then WAIT with response.
- Reset mid-WAIT abandons the outstanding request.
- The memory must not return a response for a request issued before reset; discard is cleared by reset.

Test Plan:
1. Release reset, memory returns 1 cycle after req with words 0x20080001, 0x20090002 -> imem_addr 0x0 then 0x4. IF/ID shows (0x20080001, PC 0x0, valid), then (0x20090002, 0x4), with InstValid=0 in the gap cycles.
2. Stall=1 asserted the cycle imem_valid returns the word for 0x8, held 3 cycles -> state HOLD, IF/ID unchanged. On release, IF/ID=(word, 0x8, 1) and the next imem_addr is 0xC.
3. ID holds a taken beq (Branch=1, BranchCond=1, JumpTarget=0x40) while the fetch of 0x10 is in WAIT -> IF/ID=BUBBLE/valid 0. The 0x10 response is discarded and the next imem_addr is 0x40.
4. Jump=10, JrTarget=0x0000_0103 -> next imem_addr=0x100. Jump=11 -> no redirect, sequential fetch continues.
5. Redirect in the same cycle as imem_valid -> word dropped, no extra discard, req to the target on the next cycle.
6. reset=0 mid-WAIT with pc_q=0x24 -> outputs return to reset values immediately, asynchronously. After release the first imem_addr is RESET_PC.
